// File: rtl/tc_parade_multi_if.sv
// Board-side signal bundle for the multi-road parade traffic controller:
// button/sensor inputs toward the controller, light and status outputs back.
interface tc_parade_multi_if #(
  parameter int N_ROADS = 3
);
  localparam int IDX_W = (N_ROADS > 1) ? $clog2(N_ROADS) : 1;

  logic                   P;
  logic                   R;
  logic [N_ROADS-1:0]     T;
  logic [3*N_ROADS-1:0]   L;
  logic                   TICK;
  logic [IDX_W-1:0]       GREEN_IDX;
  logic                   PARADE_ACT;

  modport master (output P, R, T, input L, TICK, GREEN_IDX, PARADE_ACT);
  modport slave  (input P, R, T, output L, TICK, GREEN_IDX, PARADE_ACT);
endinterface

// File: rtl/tc_parade_multi.sv
// Multi-road traffic controller: divides CLK_100M into a slow tick and walks one
// green road at a time through GREEN -> YELLOW -> ALL_RED, with a parade lock.
module tc_parade_multi #(
  parameter int N_ROADS      = 3,
  parameter int TICK_DIV     = 500000000,
  parameter int MIN_GREEN    = 2,
  parameter int YELLOW_TICKS = 1,
  parameter int ALLRED_TICKS = 1,
  parameter int PARADE_ROAD  = 0
) (
  input  logic             CLK_100M,
  input  logic             RESET,
  tc_parade_multi_if.slave bus
);

  localparam int IDX_W  = (N_ROADS > 1) ? $clog2(N_ROADS) : 1;
  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int SC_MAX = (MIN_GREEN > YELLOW_TICKS)
                          ? ((MIN_GREEN > ALLRED_TICKS) ? MIN_GREEN : ALLRED_TICKS)
                          : ((YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS);
  localparam int SC_W   = $clog2(SC_MAX + 1);

  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [SC_W-1:0]      SC_SAT     = SC_W'(SC_MAX);
  localparam logic [SC_W-1:0]      SC_ONE     = SC_W'(1);
  localparam logic [IDX_W-1:0]     IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0]     PARADE_IDX = IDX_W'(PARADE_ROAD);
  localparam logic [3*N_ROADS-1:0] L_RST      = {{(N_ROADS-1){3'b100}}, 3'b001};

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [SC_W-1:0]      sc_r;
  logic [SC_W-1:0]      sc_nx_s;
  logic [SC_W-1:0]      sc_inc_s;
  logic [IDX_W-1:0]     gidx_r;
  logic [IDX_W-1:0]     gidx_nx_s;
  logic [IDX_W-1:0]     nidx_r;
  logic [IDX_W-1:0]     nidx_nx_s;
  logic [IDX_W-1:0]     tgt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nx_s;
  logic                 tick_r;
  logic                 parade_r;
  logic                 parade_nx_s;
  logic                 leave_s;
  logic [3*N_ROADS-1:0] l_r;
  logic [3*N_ROADS-1:0] l_nx_s;
  int                   e_s;

  // Tick divider wrap and parade flag update (release beats request)
  always_comb begin
    cnt_nx_s    = (cnt_r == CNT_LAST) ? {CNT_W{1'b0}} : (cnt_r + CNT_ONE);
    parade_nx_s = parade_r;
    if (bus.R) begin
      parade_nx_s = 1'b0;
    end else if (bus.P) begin
      parade_nx_s = 1'b1;
    end else begin
      parade_nx_s = parade_r;
    end
  end

  // Road to serve after the current green: parade road, else next waiting road
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    logic             hit;
    cand     = 0;
    cand_idx = {IDX_W{1'b0}};
    found    = 1'b0;
    hit      = 1'b0;
    tgt_s    = (int'(gidx_r) + 1 >= N_ROADS) ? {IDX_W{1'b0}} : (gidx_r + IDX_ONE);
    for (int k = 1; k < N_ROADS; k++) begin
      cand     = int'(gidx_r) + k;
      cand     = (cand >= N_ROADS) ? (cand - N_ROADS) : cand;
      cand_idx = IDX_W'(cand);
      hit      = !found && bus.T[cand_idx];
      tgt_s    = hit ? cand_idx : tgt_s;
      found    = found | hit;
    end
    if (parade_r) begin
      tgt_s = PARADE_IDX;
    end else begin
      tgt_s = tgt_s;
    end
  end

  // Next-state logic, evaluated only on tick cycles
  always_comb begin
    state_nx_s = state_r;
    sc_nx_s    = sc_r;
    gidx_nx_s  = gidx_r;
    nidx_nx_s  = nidx_r;
    sc_inc_s   = (sc_r == SC_SAT) ? sc_r : (sc_r + SC_ONE);
    e_s        = int'(sc_r) + 1;
    leave_s    = (e_s >= MIN_GREEN) &&
                 (parade_r ? (gidx_r != PARADE_IDX) : !bus.T[gidx_r]);
    if (tick_r) begin
      case (state_r)
        ST_GREEN: begin
          if (leave_s) begin
            state_nx_s = ST_YELLOW;
            sc_nx_s    = {SC_W{1'b0}};
            nidx_nx_s  = tgt_s;
          end else begin
            sc_nx_s = sc_inc_s;
          end
        end
        ST_YELLOW: begin
          if (e_s == YELLOW_TICKS) begin
            sc_nx_s = {SC_W{1'b0}};
            if (ALLRED_TICKS == 0) begin
              state_nx_s = ST_GREEN;
              gidx_nx_s  = nidx_r;
            end else begin
              state_nx_s = ST_ALLRED;
            end
          end else begin
            sc_nx_s = sc_inc_s;
          end
        end
        ST_ALLRED: begin
          if (e_s == ALLRED_TICKS) begin
            state_nx_s = ST_GREEN;
            sc_nx_s    = {SC_W{1'b0}};
            gidx_nx_s  = nidx_r;
          end else begin
            sc_nx_s = sc_inc_s;
          end
        end
        default: begin
          // Unknown encoding: fall back to clearance, which is always safe
          state_nx_s = ST_ALLRED;
          sc_nx_s    = {SC_W{1'b0}};
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Light pattern for the upcoming state, registered with it
  always_comb begin
    l_nx_s = {N_ROADS{3'b100}};
    for (int i = 0; i < N_ROADS; i++) begin
      if (IDX_W'(i) == gidx_nx_s) begin
        case (state_nx_s)
          ST_GREEN:  l_nx_s[3*i +: 3] = 3'b001;
          ST_YELLOW: l_nx_s[3*i +: 3] = 3'b010;
          default:   l_nx_s[3*i +: 3] = 3'b100;
        endcase
      end else begin
        l_nx_s[3*i +: 3] = 3'b100;
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK_100M) begin
    if (!RESET) begin
      cnt_r    <= {CNT_W{1'b0}};
      tick_r   <= 1'b0;
      parade_r <= 1'b0;
      state_r  <= ST_GREEN;
      sc_r     <= {SC_W{1'b0}};
      gidx_r   <= {IDX_W{1'b0}};
      nidx_r   <= {IDX_W{1'b0}};
      l_r      <= L_RST;
    end else begin
      cnt_r    <= cnt_nx_s;
      tick_r   <= (cnt_nx_s == CNT_LAST);
      parade_r <= parade_nx_s;
      state_r  <= state_nx_s;
      sc_r     <= sc_nx_s;
      gidx_r   <= gidx_nx_s;
      nidx_r   <= nidx_nx_s;
      l_r      <= l_nx_s;
    end
  end

  assign bus.L          = l_r;
  assign bus.TICK       = tick_r;
  assign bus.GREEN_IDX  = gidx_r;
  assign bus.PARADE_ACT = parade_r;

endmodule

// File: tb/tb_tc_parade_multi.sv
// Bench for tc_parade_multi: directed vector table for the sequencing corners,
// then randomized buttons/sensors/resets checked against a tick-level road model.
module tb_tc_parade_multi;

  localparam int N_ROADS      = 3;
  localparam int TICK_DIV     = 4;
  localparam int MIN_GREEN    = 2;
  localparam int YELLOW_TICKS = 1;
  localparam int ALLRED_TICKS = 1;
  localparam int PARADE_ROAD  = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  tc_parade_multi_if #(.N_ROADS(N_ROADS)) bus ();

  tc_parade_multi #(
    .N_ROADS(N_ROADS), .TICK_DIV(TICK_DIV), .MIN_GREEN(MIN_GREEN),
    .YELLOW_TICKS(YELLOW_TICKS), .ALLRED_TICKS(ALLRED_TICKS), .PARADE_ROAD(PARADE_ROAD)
  ) dut (
    .CLK_100M(clk),
    .RESET(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ncyc;
    logic       rst_n;
    logic       p;
    logic       r;
    logic [2:0] t;
    logic [8:0] l;
    int         gidx;
    logic       par;
    logic       tick;
  } vec_t;

  vec_t vecs[$];

  // Road model: phase 0=green 1=yellow 2=all-red, plain tick counting
  int m_cyc, m_par, m_phase, m_ticks, m_g, m_next;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void add(input int n, input logic rs, input logic p, input logic r,
                              input logic [2:0] t, input logic [8:0] l, input int g,
                              input logic par, input logic tk);
    vec_t v;
    v.ncyc = n; v.rst_n = rs; v.p = p; v.r = r; v.t = t;
    v.l = l; v.gidx = g; v.par = par; v.tick = tk;
    vecs.push_back(v);
  endfunction

  function automatic int pick_target();
    if (m_par != 0) return PARADE_ROAD;
    for (int k = 1; k < N_ROADS; k++) begin
      if (bus.T[(m_g + k) % N_ROADS]) return (m_g + k) % N_ROADS;
    end
    return (m_g + 1) % N_ROADS;
  endfunction

  function automatic logic [3*N_ROADS-1:0] model_l();
    logic [3*N_ROADS-1:0] l;
    for (int i = 0; i < N_ROADS; i++) begin
      if (i == m_g && m_phase == 0)      l[3*i +: 3] = 3'b001;
      else if (i == m_g && m_phase == 1) l[3*i +: 3] = 3'b010;
      else                               l[3*i +: 3] = 3'b100;
    end
    return l;
  endfunction

  task automatic model_step();
    int e;
    if (!rst_n) begin
      m_cyc = 0; m_par = 0; m_phase = 0; m_ticks = 0; m_g = 0; m_next = 0;
    end else begin
      if ((m_cyc % TICK_DIV) == TICK_DIV - 1) begin
        e = m_ticks + 1;
        m_ticks = e;
        if (m_phase == 0) begin
          if (e >= MIN_GREEN && ((m_par != 0) ? (m_g != PARADE_ROAD) : (bus.T[m_g] == 1'b0))) begin
            m_next = pick_target();
            m_phase = 1;
            m_ticks = 0;
          end
        end else if (m_phase == 1) begin
          if (e == YELLOW_TICKS) begin
            m_ticks = 0;
            if (ALLRED_TICKS == 0) begin m_phase = 0; m_g = m_next; end
            else m_phase = 2;
          end
        end else begin
          if (e == ALLRED_TICKS) begin m_phase = 0; m_g = m_next; m_ticks = 0; end
        end
      end
      if (bus.R) m_par = 0;
      else if (bus.P) m_par = 1;
      m_cyc++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    logic [3*N_ROADS-1:0] prev_l;
    logic [3*N_ROADS-1:0] cur_l;
    int   nonred;
    logic bad;

    // ncyc rst p r T  expected L  gidx par tick (cycle index after release in notes)
    add(3, 1'b0, 1'b0, 1'b0, 3'b000, 9'b100_100_001, 0, 1'b0, 1'b0); // reset held
    add(3, 1'b1, 1'b0, 1'b0, 3'b000, 9'b100_100_001, 0, 1'b0, 1'b1); // c3 first tick
    add(1, 1'b1, 1'b0, 1'b0, 3'b000, 9'b100_100_001, 0, 1'b0, 1'b0); // c4
    add(4, 1'b1, 1'b0, 1'b0, 3'b000, 9'b100_100_010, 0, 1'b0, 1'b0); // c8 yellow0
    add(4, 1'b1, 1'b0, 1'b0, 3'b000, 9'b100_100_100, 0, 1'b0, 1'b0); // c12 all-red
    add(4, 1'b1, 1'b0, 1'b0, 3'b000, 9'b100_001_100, 1, 1'b0, 1'b0); // c16 green1
    add(16, 1'b1, 1'b0, 1'b0, 3'b000, 9'b001_100_100, 2, 1'b0, 1'b0); // c32 green2
    add(16, 1'b1, 1'b0, 1'b0, 3'b000, 9'b100_100_001, 0, 1'b0, 1'b0); // c48 green0
    add(8, 1'b1, 1'b0, 1'b0, 3'b100, 9'b100_100_010, 0, 1'b0, 1'b0); // c56 yellow0
    add(8, 1'b1, 1'b0, 1'b0, 3'b100, 9'b001_100_100, 2, 1'b0, 1'b0); // c64 road1 skipped
    add(16, 1'b1, 1'b0, 1'b0, 3'b100, 9'b001_100_100, 2, 1'b0, 1'b0); // c80 held by T2
    add(12, 1'b1, 1'b0, 1'b0, 3'b010, 9'b100_001_100, 1, 1'b0, 1'b0); // c92 green1
    add(1, 1'b1, 1'b1, 1'b0, 3'b010, 9'b100_001_100, 1, 1'b1, 1'b0); // c93 parade set
    add(7, 1'b1, 1'b0, 1'b0, 3'b010, 9'b100_010_100, 1, 1'b1, 1'b0); // c100 yellow1
    add(8, 1'b1, 1'b0, 1'b0, 3'b110, 9'b100_100_001, 0, 1'b1, 1'b0); // c108 parade road
    add(16, 1'b1, 1'b0, 1'b0, 3'b110, 9'b100_100_001, 0, 1'b1, 1'b0); // c124 held
    add(1, 1'b1, 1'b0, 1'b1, 3'b110, 9'b100_100_001, 0, 1'b0, 1'b0); // c125 release
    add(3, 1'b1, 1'b0, 1'b0, 3'b110, 9'b100_100_010, 0, 1'b0, 1'b0); // c128 yellow0
    add(1, 1'b1, 1'b1, 1'b1, 3'b110, 9'b100_100_010, 0, 1'b0, 1'b0); // c129 R wins
    add(1, 1'b1, 1'b1, 1'b0, 3'b110, 9'b100_100_010, 0, 1'b1, 1'b0); // c130 P in yellow
    add(6, 1'b1, 1'b0, 1'b0, 3'b000, 9'b100_001_100, 1, 1'b1, 1'b0); // c136 next_idx kept
    add(8, 1'b1, 1'b0, 1'b0, 3'b000, 9'b100_010_100, 1, 1'b1, 1'b0); // c144 redirect
    add(8, 1'b1, 1'b0, 1'b0, 3'b000, 9'b100_100_001, 0, 1'b1, 1'b0); // c152 parade road
    add(1, 1'b1, 1'b0, 1'b1, 3'b000, 9'b100_100_001, 0, 1'b0, 1'b0); // c153 release
    add(15, 1'b1, 1'b0, 1'b0, 3'b100, 9'b001_100_100, 2, 1'b0, 1'b0); // c168 green2
    add(9, 1'b1, 1'b0, 1'b0, 3'b000, 9'b010_100_100, 2, 1'b0, 1'b0); // c177 yellow2
    add(1, 1'b0, 1'b0, 1'b0, 3'b000, 9'b100_100_001, 0, 1'b0, 1'b0); // reset mid-yellow
    add(3, 1'b1, 1'b0, 1'b0, 3'b000, 9'b100_100_001, 0, 1'b0, 1'b1); // c3 tick restarts

    bus.P = 1'b0; bus.R = 1'b0; bus.T = 3'b000; rst_n = 1'b0;
    m_cyc = 0; m_par = 0; m_phase = 0; m_ticks = 0; m_g = 0; m_next = 0;
    @(negedge clk);

    foreach (vecs[n]) begin
      v = vecs[n];
      rst_n = v.rst_n; bus.P = v.p; bus.R = v.r; bus.T = v.t;
      repeat (v.ncyc) cycle();
      check($sformatf("vec%0d_L", n),      32'(bus.L),          32'(v.l));
      check($sformatf("vec%0d_gidx", n),   32'(bus.GREEN_IDX),  32'(v.gidx));
      check($sformatf("vec%0d_parade", n), 32'(bus.PARADE_ACT), 32'(v.par));
      check($sformatf("vec%0d_tick", n),   32'(bus.TICK),       32'(v.tick));
    end

    // Tick cadence: table ended at c=3, so pulses land on c=7 and c=11
    bus.P = 1'b0; bus.R = 1'b0;
    for (int c = 4; c < 12; c++) begin
      cycle();
      check($sformatf("tick_c%0d", c), 32'(bus.TICK), 32'((c % TICK_DIV) == TICK_DIV - 1));
    end

    // Randomized run against the model plus light-safety invariants
    prev_l = bus.L;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(399) != 0);
      if ($urandom_range(11) == 0) bus.T = 3'($urandom_range(7));
      bus.P = ($urandom_range(29) == 0);
      bus.R = ($urandom_range(39) == 0);
      cycle();
      check("rnd_L",      32'(bus.L),          32'(model_l()));
      check("rnd_tick",   32'(bus.TICK),       32'((m_cyc % TICK_DIV) == TICK_DIV - 1));
      check("rnd_gidx",   32'(bus.GREEN_IDX),  32'(m_g));
      check("rnd_parade", 32'(bus.PARADE_ACT), 32'(m_par));
      cur_l  = bus.L;
      nonred = 0;
      bad    = 1'b0;
      for (int i = 0; i < N_ROADS; i++) begin
        if (!$onehot(cur_l[3*i +: 3])) bad = 1'b1;
        if (cur_l[3*i +: 3] != 3'b100) nonred++;
        if (rst_n && prev_l[3*i +: 3] == 3'b001 && cur_l[3*i +: 3] == 3'b100) bad = 1'b1;
      end
      check("inv_lights", 32'(bad), 32'(0));
      check("inv_nonred", 32'(nonred <= 1), 32'(1));
      prev_l = cur_l;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
